ks_xor_stage: RTL and testbench

Downstream consumer of the 32-bit PRNG keystream generator. Buffers keystream words in a small FIFO and XORs each one with a plaintext word to produce ciphertext (or recovers plaintext from ciphertext).
Keystream and data each use a valid/ready handshake, and the output is registered. Sits between the splitmix generator and the data path of the stream-cipher datapath.

---
 rtl/ks_xor_stage.sv | 137 +++++++++++++
 tb/tb_ks_xor_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_xor_stage.sv
// ks_xor_stage: buffers keystream words from the PRNG in a small FIFO and
// XORs each buffered word with exactly one incoming data word, producing a
// registered result. Encryption and decryption are the same operation.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where valid and ready are both high. A source holds valid and
// its data stable until the transfer; ready never depends on the same
// channel's valid. ks_ready is a function of registered state only, and
// in_ready depends on registered state, out_ready and flush.
module ks_xor_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,   // power of 2, at least 2
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ks_valid,
    input  logic [WIDTH-1:0]         ks_data,
    output logic                     ks_ready,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   ks_level,
    output logic [CNT_W-1:0]         word_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Keystream storage and pointers; pointers wrap naturally at DEPTH.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    // Occupancy kept in its own counter so full and empty are unambiguous.
    logic [LVL_W-1:0] level_q, level_d;

    // Registered output stage and accepted-word counter.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    logic             push;
    logic             accept;
    logic [WIDTH-1:0] head;

    // Ready signals: a full FIFO refuses pushes even if a pop happens this
    // cycle; data is only taken when a keystream word is already buffered
    // and the output register is free or being drained.
    always_comb begin
        ks_ready = (level_q != FULL_LVL);
        in_ready = (level_q != '0) && (!out_valid_q || out_ready) && !flush;
    end

    // Next-state logic: flush wins over everything except word_count.
    always_comb begin
        push         = ks_valid && ks_ready && !flush;
        accept       = in_valid && in_ready;
        head         = mem_q[rd_ptr_q];
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        word_count_d = word_count_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ks_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end

            if (accept) begin
                // The head is read from registered storage, so a word pushed
                // this cycle is never used before the next cycle.
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                out_data_d   = in_data ^ head;
                out_valid_d  = 1'b1;
                word_count_d = word_count_q + CNT_W'(1);
            end else if (out_valid_q && out_ready) begin
                // Result consumed with nothing new behind it; data is kept.
                out_valid_d = 1'b0;
            end

            case ({push, accept})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            word_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            word_count_q <= word_count_d;
        end
    end

    // Output mapping.
    always_comb begin
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        ks_level   = level_q;
        word_count = word_count_q;
    end

endmodule

// File: tb/tb_ks_xor_stage.sv
// Directed testbench for ks_xor_stage with a decoupled output scoreboard.
module tb_ks_xor_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             ks_valid;
    logic [WIDTH-1:0] ks_data;
    logic             ks_ready;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [3:0]       ks_level;
    logic [CNT_W-1:0] word_count;

    ks_xor_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ks_valid   (ks_valid),
        .ks_data    (ks_data),
        .ks_ready   (ks_ready),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .ks_level   (ks_level),
        .word_count (word_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_ks_q[$];
    logic             m_ov;
    logic [CNT_W-1:0] m_cnt;
    int               n_vec;
    int               n_err;
    logic             last_in_ready;
    logic [CNT_W-1:0] saved_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ks_q.delete();
        m_ov  = 1'b0;
        m_cnt = '0;
    endtask

    // One clock cycle of stimulus; ready/level/state checked against the model
    // on the falling edge, then the model advances as the DUT will at the edge.
    task automatic cycle(input logic kv, input logic [31:0] kd, input logic iv,
                         input logic [31:0] id, input logic ordy, input logic fl);
        logic m_ks_rdy;
        logic m_in_rdy;
        logic m_push;
        logic m_acc;
        ks_valid  = kv;
        ks_data   = kd;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        m_ks_rdy = (m_ks_q.size() != DEPTH);
        m_in_rdy = (m_ks_q.size() != 0) && (!m_ov || ordy) && !fl;
        chk("ks_ready", 32'(ks_ready), 32'(m_ks_rdy));
        chk("in_ready", 32'(in_ready), 32'(m_in_rdy));
        chk("ks_level", 32'(ks_level), 32'(m_ks_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("word_count", word_count, m_cnt);
        last_in_ready = in_ready;
        if (fl) begin
            if (m_ov && !ordy && exp_q.size() > 0) void'(exp_q.pop_back());
            m_ks_q.delete();
            m_ov = 1'b0;
        end else begin
            m_push = kv && m_ks_rdy;
            m_acc  = iv && m_in_rdy;
            if (m_acc) begin
                exp_q.push_back(id ^ m_ks_q.pop_front());
                m_ov  = 1'b1;
                m_cnt = m_cnt + 1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (m_push) m_ks_q.push_back(kd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic push_ks(input logic [31:0] kd);
        cycle(1'b1, kd, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic accept(input logic [31:0] id, input logic ordy);
        cycle(1'b0, 32'h0, 1'b1, id, ordy, 1'b0);
    endtask

    // Monitor: every output handshake pops and compares the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got %h expected none at %0t", out_data, $time);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        last_in_ready = 1'b0;
        ks_valid = 1'b0; ks_data = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; flush = 1'b0;
        model_reset();

        // Asynchronous reset mid-cycle, checked before any clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_ks_level", 32'(ks_level), 32'd0);
        chk("rst_ks_ready", 32'(ks_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic XOR
        push_ks(32'hA5A5A5A5);
        accept(32'h0F0F0F0F, 1'b1);
        chk("basic_out_data", out_data, 32'hAAAAAAAA);
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_word_count", word_count, 32'd1);
        chk("basic_ks_level", 32'(ks_level), 32'd0);
        idle();

        // FIFO order across pointer wrap
        for (int i = 1; i <= 8; i++) push_ks(32'(i));
        chk("full_ks_level", 32'(ks_level), 32'd8);
        chk("full_ks_ready", 32'(ks_ready), 32'd0);
        accept(32'h0, 1'b1);
        for (int i = 9; i <= 12; i++) cycle(1'b1, 32'(i), 1'b1, 32'h0, 1'b1, 1'b0);
        chk("wrap_ks_level", 32'(ks_level), 32'd7);
        for (int i = 0; i < 7; i++) accept(32'h0, 1'b1);
        idle();
        chk("wrap_word_count", word_count, 32'd13);

        // Backpressure
        for (int i = 0; i < 8; i++) push_ks(32'hFFFFFFFF);
        accept(32'h12345678, 1'b1);
        for (int i = 0; i < 3; i++) begin
            accept(32'hAAAA5555, 1'b0);
            chk("bp_in_ready", 32'(last_in_ready), 32'd0);
            chk("bp_out_data", out_data, 32'hEDCBA987);
        end
        accept(32'h0000FFFF, 1'b1);
        chk("bp_release_out", out_data, 32'hFFFF0000);
        for (int i = 0; i < 6; i++) accept(32'(i * 3 + 1), 1'b1);
        idle();

        // Empty stall, then simultaneous push and pop
        accept(32'h55555555, 1'b1);
        chk("empty_in_ready", 32'(last_in_ready), 32'd0);
        push_ks(32'h11111111);
        cycle(1'b1, 32'h22222222, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("pp_ks_level", 32'(ks_level), 32'd1);
        chk("pp_out_old", out_data, 32'h11111111);
        accept(32'h0, 1'b1);
        chk("pp_out_new", out_data, 32'h22222222);
        idle();

        // Flush priority
        for (int i = 0; i < 6; i++) push_ks(32'h30 + 32'(i));
        accept(32'h0, 1'b0);
        chk("pre_flush_level", 32'(ks_level), 32'd5);
        saved_cnt = word_count;
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 32'h1, 1'b0, 1'b1);
        chk("flush_ks_level", 32'(ks_level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_word_count", word_count, saved_cnt);
        chk("flush_ks_ready", 32'(ks_ready), 32'd1);
        push_ks(32'h77777777);
        accept(32'h0, 1'b1);
        chk("post_flush_out", out_data, 32'h77777777);
        idle();

        // Reset in the middle of a transfer
        for (int i = 0; i < 3; i++) push_ks(32'h900 + 32'(i));
        accept(32'h1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ks_level", 32'(ks_level), 32'd0);
        chk("mid_rst_word_count", word_count, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
